// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered instruction decode stage for the 16-bit
//                accumulator CPU. Turns the SS|OOOO|operand word into
//                control enables behind a valid/ready handshake with
//                one-cycle latency, and folds PFX operand-extension
//                prefixes into the following instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int INST_W = 16,
    parameter int PFX_W  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INST_W-1:0]           inst,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  op,
    output logic [INST_W-6+PFX_W-1:0]   operand,
    output logic                        has_pfx,
    output logic [1:0]                  data_src,
    output logic                        ce_reg,
    output logic                        ce_mem,
    output logic                        ce_a,
    output logic                        ce_cy,
    output logic                        ce_bank,
    output logic                        is_jump,
    output logic                        call,
    output logic                        ret,
    output logic [1:0]                  jump_cond
);

    localparam int OPND_W = INST_W - 6;
    localparam int OUT_W  = OPND_W + PFX_W;

    // data_src_t encodings
    localparam logic [1:0] c_SRC_MEM_ADDR = 2'b00;
    localparam logic [1:0] c_SRC_IMM      = 2'b01;
    localparam logic [1:0] c_SRC_INDIRECT = 2'b10;
    localparam logic [1:0] c_SRC_REG      = 2'b11;

    // Opcodes with dedicated decode behaviour
    localparam logic [3:0] c_OPC_NOP  = 4'b0000;
    localparam logic [3:0] c_OPC_ST   = 4'b1100;
    localparam logic [3:0] c_OPC_BANK = 4'b1101;
    localparam logic [3:0] c_OPC_CALL = 4'b1110;
    localparam logic [3:0] c_OPC_RET  = 4'b1111;

    localparam logic [1:0] c_JMP_ALWAYS = 2'b00;

    // Instruction fields
    logic [1:0]        w_src;
    logic [3:0]        w_opc;
    logic [OPND_W-1:0] w_base;
    logic [PFX_W-1:0]  w_payload;

    assign w_src     = inst[INST_W-1:INST_W-2];
    assign w_opc     = inst[INST_W-3:INST_W-6];
    assign w_base    = inst[OPND_W-1:0];
    assign w_payload = inst[PFX_W-1:0];

    // Handshake
    logic r_out_valid;
    logic w_accept;
    logic w_is_pfx;

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_is_pfx = (w_opc == c_OPC_NOP) && (w_src == c_SRC_IMM);

    // Pending prefix
    logic             r_pfx_pend;
    logic [PFX_W-1:0] r_pfx_reg;

    // Decoded controls for the word currently on inst
    logic [2:0]       w_op;
    logic [OUT_W-1:0] w_operand;
    logic             w_has_pfx;
    logic             w_ce_reg;
    logic             w_ce_mem;
    logic             w_ce_a;
    logic             w_ce_cy;
    logic             w_ce_bank;
    logic             w_is_jump;
    logic             w_call;
    logic             w_ret;
    logic [1:0]       w_jump_cond;

    // Combinational decode of the incoming word, including prefix merge
    always_comb begin
        w_op        = w_opc[2:0];
        w_has_pfx   = r_pfx_pend;
        w_operand   = {(r_pfx_pend ? r_pfx_reg : {PFX_W{1'b0}}), w_base};
        w_ce_reg    = (w_opc == c_OPC_ST) && (w_src == c_SRC_REG);
        w_ce_mem    = (w_opc == c_OPC_ST) &&
                      ((w_src == c_SRC_MEM_ADDR) || (w_src == c_SRC_INDIRECT));
        w_ce_a      = ~w_opc[3] && (w_opc != c_OPC_NOP);
        w_ce_cy     = (w_opc[3:1] == 3'b001) || (w_opc[3:2] == 2'b01);
        w_ce_bank   = (w_opc == c_OPC_BANK);
        w_is_jump   = (w_opc[3:2] == 2'b10) || (w_opc[3:1] == 3'b111);
        w_jump_cond = (w_opc[3:1] == 3'b111) ? c_JMP_ALWAYS : w_opc[1:0];
        w_call      = (w_opc == c_OPC_CALL);
        w_ret       = (w_opc == c_OPC_RET);
    end

    // Output beat registers
    logic [2:0]       r_op;
    logic [OUT_W-1:0] r_operand;
    logic             r_has_pfx;
    logic [1:0]       r_data_src;
    logic             r_ce_reg;
    logic             r_ce_mem;
    logic             r_ce_a;
    logic             r_ce_cy;
    logic             r_ce_bank;
    logic             r_is_jump;
    logic             r_call;
    logic             r_ret;
    logic [1:0]       r_jump_cond;

    // Handshake state and prefix tracking; flush drops beat and prefix
    // but leaves the data registers holding their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pfx_pend  <= 1'b0;
            r_pfx_reg   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_pfx_pend  <= 1'b0;
            r_pfx_reg   <= '0;
        end else if (w_accept && w_is_pfx) begin
            // A prefix never produces a beat; any held beat drains now.
            r_out_valid <= r_out_valid & ~out_ready;
            r_pfx_pend  <= 1'b1;
            r_pfx_reg   <= w_payload;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pfx_pend  <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Decoded data registers load only on a non-prefix accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_operand   <= '0;
            r_has_pfx   <= 1'b0;
            r_data_src  <= c_SRC_MEM_ADDR;
            r_ce_reg    <= 1'b0;
            r_ce_mem    <= 1'b0;
            r_ce_a      <= 1'b0;
            r_ce_cy     <= 1'b0;
            r_ce_bank   <= 1'b0;
            r_is_jump   <= 1'b0;
            r_call      <= 1'b0;
            r_ret       <= 1'b0;
            r_jump_cond <= c_JMP_ALWAYS;
        end else if (!flush && w_accept && !w_is_pfx) begin
            r_op        <= w_op;
            r_operand   <= w_operand;
            r_has_pfx   <= w_has_pfx;
            r_data_src  <= w_src;
            r_ce_reg    <= w_ce_reg;
            r_ce_mem    <= w_ce_mem;
            r_ce_a      <= w_ce_a;
            r_ce_cy     <= w_ce_cy;
            r_ce_bank   <= w_ce_bank;
            r_is_jump   <= w_is_jump;
            r_call      <= w_call;
            r_ret       <= w_ret;
            r_jump_cond <= w_jump_cond;
        end
    end

    assign out_valid = r_out_valid;
    assign op        = r_op;
    assign operand   = r_operand;
    assign has_pfx   = r_has_pfx;
    assign data_src  = r_data_src;
    assign ce_reg    = r_ce_reg;
    assign ce_mem    = r_ce_mem;
    assign ce_a      = r_ce_a;
    assign ce_cy     = r_ce_cy;
    assign ce_bank   = r_ce_bank;
    assign is_jump   = r_is_jump;
    assign call      = r_call;
    assign ret       = r_ret;
    assign jump_cond = r_jump_cond;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] operand;
        logic        has_pfx;
        logic [1:0]  data_src;
        logic        ce_reg;
        logic        ce_mem;
        logic        ce_a;
        logic        ce_cy;
        logic        ce_bank;
        logic        is_jump;
        logic        call;
        logic        ret;
        logic [1:0]  jump_cond;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  op;
    logic [15:0] operand;
    logic        has_pfx;
    logic [1:0]  data_src;
    logic        ce_reg, ce_mem, ce_a, ce_cy, ce_bank;
    logic        is_jump, call, ret;
    logic [1:0]  jump_cond;

    always #5 clk = ~clk;

    decode_stage #(.INST_W(16), .PFX_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .operand(operand), .has_pfx(has_pfx), .data_src(data_src),
        .ce_reg(ce_reg), .ce_mem(ce_mem), .ce_a(ce_a), .ce_cy(ce_cy),
        .ce_bank(ce_bank), .is_jump(is_jump), .call(call), .ret(ret),
        .jump_cond(jump_cond)
    );

    beat_t obs;
    assign obs = {op, operand, has_pfx, data_src, ce_reg, ce_mem, ce_a, ce_cy,
                  ce_bank, is_jump, call, ret, jump_cond};

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    beat_t       m_beat  = '0;
    logic        m_pend  = 1'b0;
    int unsigned m_preg  = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic model_is_pfx(input logic [15:0] w);
        int unsigned src, opc;
        src = w / 16384;
        opc = (w / 1024) % 16;
        return (src == 1) && (opc == 0);
    endfunction

    // Decode rules expressed as arithmetic over the opcode value
    function automatic beat_t model_decode(input logic [15:0] w, input logic pend,
                                           input int unsigned preg);
        beat_t b;
        int unsigned src, opc, base;
        src  = w / 16384;
        opc  = (w / 1024) % 16;
        base = w % 1024;
        b = '0;
        b.op        = 3'(opc % 8);
        b.operand   = 16'(pend ? preg * 1024 + base : base);
        b.has_pfx   = pend;
        b.data_src  = 2'(src);
        b.ce_reg    = (opc == 12) && (src == 3);
        b.ce_mem    = (opc == 12) && (src == 0 || src == 2);
        b.ce_a      = (opc < 8) && (opc != 0);
        b.ce_cy     = (opc >= 2) && (opc <= 7);
        b.ce_bank   = (opc == 13);
        b.is_jump   = (opc >= 8 && opc <= 11) || (opc >= 14);
        b.jump_cond = (opc >= 14) ? 2'd0 : 2'(opc % 4);
        b.call      = (opc == 14);
        b.ret       = (opc == 15);
        return b;
    endfunction

    // One clock: check in_ready, advance the model, check registered state
    task automatic cycle();
        logic exp_rdy;
        #1;
        exp_rdy = !m_valid || out_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_pend = 1'b0; m_preg = 0; m_beat = '0;
        end else if (flush) begin
            m_valid = 1'b0; m_pend = 1'b0; m_preg = 0;
        end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (in_valid && exp_rdy) begin
                if (model_is_pfx(inst)) begin
                    m_pend = 1'b1;
                    m_preg = inst % 64;
                end else begin
                    m_beat  = model_decode(inst, m_pend, m_preg);
                    m_valid = 1'b1;
                    m_pend  = 1'b0;
                end
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("beat", 32'(obs), 32'(m_beat));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_beat", 32'(obs), 32'd0);

        // LD #0x5A
        in_valid = 1'b1; inst = 16'h445A; out_ready = 1'b1;
        cycle();
        chk("ld_valid", {31'd0, out_valid}, 32'd1);
        chk("ld_op", {29'd0, op}, 32'd1);
        chk("ld_src", {30'd0, data_src}, 32'd1);
        chk("ld_operand", {16'd0, operand}, 32'h005A);
        chk("ld_ce_a", {31'd0, ce_a}, 32'd1);
        chk("ld_ce_cy", {31'd0, ce_cy}, 32'd0);
        chk("ld_has_pfx", {31'd0, has_pfx}, 32'd0);

        // PFX 0x2A then LD 0x3FF, then ST R3
        inst = 16'h402A;
        cycle();
        chk("pfx_no_beat", {31'd0, out_valid}, 32'd0);
        inst = 16'h07FF;
        cycle();
        chk("pfx_ld_valid", {31'd0, out_valid}, 32'd1);
        chk("pfx_ld_operand", {16'd0, operand}, 32'hABFF);
        chk("pfx_ld_has_pfx", {31'd0, has_pfx}, 32'd1);
        inst = 16'hF003;
        cycle();
        chk("st_ce_reg", {31'd0, ce_reg}, 32'd1);
        chk("st_ce_mem", {31'd0, ce_mem}, 32'd0);
        chk("st_operand", {16'd0, operand}, 32'h0003);
        chk("st_has_pfx", {31'd0, has_pfx}, 32'd0);

        // Backpressure with CALL 0x123 held
        inst = 16'h3923;
        cycle();
        out_ready = 1'b0; inst = 16'h445A;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_operand", {16'd0, operand}, 32'h0123);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_call", {31'd0, call}, 32'd1);
        chk("rel_is_jump", {31'd0, is_jump}, 32'd1);
        chk("rel_jump_cond", {30'd0, jump_cond}, 32'd0);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        chk("rel_next_op", {29'd0, op}, 32'd1);
        chk("rel_next_valid", {31'd0, out_valid}, 32'd1);

        // Flush discards the pending prefix and the concurrent instruction
        inst = 16'h4015;
        cycle();
        flush = 1'b1; inst = 16'h07FF;
        cycle();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        cycle();
        chk("flush_operand", {16'd0, operand}, 32'h03FF);
        chk("flush_has_pfx", {31'd0, has_pfx}, 32'd0);

        // Reset with a beat held under backpressure
        inst = 16'h3923; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        rst = 1'b1; flush = 1'b1;
        cycle();
        rst = 1'b0; flush = 1'b0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_beat", 32'(obs), 32'd0);
        #1;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset with a prefix pending, then LD carries no prefix
        in_valid = 1'b1; out_ready = 1'b1; inst = 16'h403F;
        cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b1; inst = 16'h07FF;
        cycle();
        chk("prst_operand", {16'd0, operand}, 32'h03FF);
        chk("prst_has_pfx", {31'd0, has_pfx}, 32'd0);

        // Sweep all source/opcode combinations with streaming drain
        for (int i = 0; i < 64; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[15:10] = 6'(i);
            inst = w;
            cycle();
        end
        inst = 16'h4000;
        cycle();
        chk("sweep_pfx_no_beat", {31'd0, out_valid}, 32'd0);
        inst = 16'h0000;
        cycle();
        chk("sweep_nop_valid", {31'd0, out_valid}, 32'd1);
        chk("sweep_nop_ce", {27'd0, ce_reg, ce_mem, ce_a, ce_cy, ce_bank}, 32'd0);
        chk("sweep_nop_pfxd", {31'd0, has_pfx}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:10] = 6'b010000;
            inst      = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
